// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - opcodes, state encodings and datapath select codes for the multicycle control FSM
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_ALUWB    = 4'd3,
        S_MEMADDR  = 4'd4,
        S_MEMRD    = 4'd5,
        S_MEMWB    = 4'd6,
        S_MEMWR    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JALR_LNK = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_ITYPE,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_ILLEGAL
    } op_class_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASSB  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - shared instruction/data memory request handshake
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_classifier.sv
// rtl/multicycle_control_fsm_classifier.sv - combinational opcode to instruction class decode
module opcode_classifier
    import riscv_ctrl_pkg::*;
#(
    parameter int SUPPORT_JUMPS = 1,
    parameter int SUPPORT_UTYPE = 1
) (
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    // Disabled instruction groups fall through to ILLEGAL so the FSM treats them like any unknown opcode.
    always_comb begin
        op_class = C_ILLEGAL;
        case (opcode)
            OP_RTYPE:  op_class = C_RTYPE;
            OP_ITYPE:  op_class = C_ITYPE;
            OP_LOAD:   op_class = C_LOAD;
            OP_STORE:  op_class = C_STORE;
            OP_BRANCH: op_class = C_BRANCH;
            OP_JAL:    op_class = (SUPPORT_JUMPS != 0) ? C_JAL   : C_ILLEGAL;
            OP_JALR:   op_class = (SUPPORT_JUMPS != 0) ? C_JALR  : C_ILLEGAL;
            OP_LUI:    op_class = (SUPPORT_UTYPE != 0) ? C_LUI   : C_ILLEGAL;
            OP_AUIPC:  op_class = (SUPPORT_UTYPE != 0) ? C_AUIPC : C_ILLEGAL;
            default:   op_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I main control state machine
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int SUPPORT_JUMPS   = 1,
    parameter int SUPPORT_UTYPE   = 1,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                opcode,
    multicycle_control_fsm_if.master  mem,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      pc_write_cond,
    output logic                      reg_write,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [1:0]                alu_op,
    output logic [1:0]                result_src,
    output logic                      retire,
    output logic                      illegal,
    output logic [3:0]                state_o
);

    state_t    state;
    state_t    state_next;
    op_class_t op_class;

    logic       mem_req_d;
    logic       mem_we_d;
    logic       adr_src_d;
    logic       ir_write_d;
    logic       pc_write_d;
    logic       pc_write_cond_d;
    logic       reg_write_d;
    logic [1:0] alu_src_a_d;
    logic [1:0] alu_src_b_d;
    logic [1:0] alu_op_d;
    logic [1:0] result_src_d;
    logic       retire_d;
    logic       illegal_d;

    opcode_classifier #(
        .SUPPORT_JUMPS (SUPPORT_JUMPS),
        .SUPPORT_UTYPE (SUPPORT_UTYPE)
    ) u_classifier (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        mem_req_d       = 1'b0;
        mem_we_d        = 1'b0;
        adr_src_d       = 1'b0;
        ir_write_d      = 1'b0;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = SRCA_PC;
        alu_src_b_d     = SRCB_RS2;
        alu_op_d        = ALU_ADD;
        result_src_d    = RES_ALUOUT;
        retire_d        = 1'b0;
        illegal_d       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_a_d  = SRCA_PC;
                alu_src_b_d  = SRCB_FOUR;
                result_src_d = RES_ALU;
                if (mem.mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target oldPC+imm is parked in ALUOut while the class is resolved.
                alu_src_a_d = SRCA_OLDPC;
                alu_src_b_d = SRCB_IMM;
                case (op_class)
                    C_RTYPE, C_ITYPE: state_next = S_EXEC;
                    C_LOAD, C_STORE:  state_next = S_MEMADDR;
                    C_BRANCH:         state_next = S_BRANCH;
                    C_JAL:            state_next = S_JAL;
                    C_JALR:           state_next = S_JALR_ADR;
                    C_LUI:            state_next = S_LUI;
                    C_AUIPC:          state_next = S_ALUWB;
                    default:          state_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_EXEC: begin
                alu_src_a_d = SRCA_RS1;
                if (op_class == C_RTYPE) begin
                    alu_src_b_d = SRCB_RS2;
                    alu_op_d    = ALU_FUNCT;
                end else begin
                    alu_src_b_d = SRCB_IMM;
                    alu_op_d    = ALU_ADD;
                end
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_d  = 1'b1;
                result_src_d = RES_ALUOUT;
                retire_d     = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMADDR: begin
                alu_src_a_d = SRCA_RS1;
                alu_src_b_d = SRCB_IMM;
                state_next  = (op_class == C_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
                if (mem.mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                result_src_d = RES_MEM;
                retire_d     = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                adr_src_d = 1'b1;
                if (mem.mem_ready) begin
                    retire_d   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a_d     = SRCA_RS1;
                alu_src_b_d     = SRCB_RS2;
                alu_op_d        = ALU_SUB;
                result_src_d    = RES_ALUOUT;
                pc_write_cond_d = 1'b1;
                retire_d        = 1'b1;
                state_next      = S_FETCH;
            end
            S_JAL, S_JALR_LNK: begin
                // PC takes the target held in ALUOut while the ALU forms the link address oldPC+4.
                pc_write_d   = 1'b1;
                result_src_d = RES_ALUOUT;
                alu_src_a_d  = SRCA_OLDPC;
                alu_src_b_d  = SRCB_FOUR;
                state_next   = S_ALUWB;
            end
            S_JALR_ADR: begin
                alu_src_a_d = SRCA_RS1;
                alu_src_b_d = SRCB_IMM;
                state_next  = S_JALR_LNK;
            end
            S_LUI: begin
                alu_src_b_d = SRCB_IMM;
                alu_op_d    = ALU_PASSB;
                state_next  = S_ALUWB;
            end
            S_TRAP: begin
                illegal_d  = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset forces every output low in the same cycle, even before the state register has returned to FETCH.
    assign mem.mem_req    = rst ? 1'b0 : mem_req_d;
    assign mem.mem_we     = rst ? 1'b0 : mem_we_d;
    assign mem.adr_src    = rst ? 1'b0 : adr_src_d;
    assign ir_write       = rst ? 1'b0 : ir_write_d;
    assign pc_write       = rst ? 1'b0 : pc_write_d;
    assign pc_write_cond  = rst ? 1'b0 : pc_write_cond_d;
    assign reg_write      = rst ? 1'b0 : reg_write_d;
    assign alu_src_a      = rst ? 2'd0 : alu_src_a_d;
    assign alu_src_b      = rst ? 2'd0 : alu_src_b_d;
    assign alu_op         = rst ? 2'd0 : alu_op_d;
    assign result_src     = rst ? 2'd0 : result_src_d;
    assign retire         = rst ? 1'b0 : retire_d;
    assign illegal        = rst ? 1'b0 : illegal_d;
    assign state_o        = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - table-driven scoreboard bench for the multicycle control FSM
module tb_multicycle_control_fsm;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC = 4'd2, ALUWB = 4'd3;
    localparam logic [3:0] MEMADDR = 4'd4, MEMRD = 4'd5, MEMWB = 4'd6, MEMWR = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8, JAL = 4'd9, JALR_ADR = 4'd10, JALR_LNK = 4'd11;
    localparam logic [3:0] LUI = 4'd12, TRAP = 4'd13;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] rs;
        logic       retire;
        logic       illegal;
        logic [3:0] st;
    } obs_t;

    // st holds one state per nibble (step 0 in the low nibble), rdy one mem_ready bit per step.
    typedef struct packed {
        logic [6:0]  opc;
        logic [4:0]  n;
        logic [1:0]  dut;
        logic [63:0] st;
        logic [15:0] rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm_if bus0 ();
    multicycle_control_fsm_if bus1 ();
    multicycle_control_fsm_if bus2 ();
    assign bus0.mem_ready = mem_ready;
    assign bus1.mem_ready = mem_ready;
    assign bus2.mem_ready = mem_ready;

    logic       irw0, pcw0, pcc0, rgw0, ret0, ill0;
    logic [1:0] sa0, sb0, op0, rs0;
    logic [3:0] st0;
    logic       irw1, pcw1, pcc1, rgw1, ret1, ill1;
    logic [1:0] sa1, sb1, op1, rs1;
    logic [3:0] st1;
    logic       irw2, pcw2, pcc2, rgw2, ret2, ill2;
    logic [1:0] sa2, sb2, op2, rs2;
    logic [3:0] st2;

    multicycle_control_fsm u_dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(bus0.master),
        .ir_write(irw0), .pc_write(pcw0), .pc_write_cond(pcc0), .reg_write(rgw0),
        .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(op0), .result_src(rs0),
        .retire(ret0), .illegal(ill0), .state_o(st0)
    );

    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(0)) u_dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(bus1.master),
        .ir_write(irw1), .pc_write(pcw1), .pc_write_cond(pcc1), .reg_write(rgw1),
        .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(op1), .result_src(rs1),
        .retire(ret1), .illegal(ill1), .state_o(st1)
    );

    multicycle_control_fsm #(.SUPPORT_JUMPS(0), .SUPPORT_UTYPE(0)) u_dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(bus2.master),
        .ir_write(irw2), .pc_write(pcw2), .pc_write_cond(pcc2), .reg_write(rgw2),
        .alu_src_a(sa2), .alu_src_b(sb2), .alu_op(op2), .result_src(rs2),
        .retire(ret2), .illegal(ill2), .state_o(st2)
    );

    obs_t obs0, obs1, obs2;
    assign obs0 = {bus0.mem_req, bus0.mem_we, bus0.adr_src, irw0, pcw0, pcc0, rgw0, sa0, sb0, op0, rs0, ret0, ill0, st0};
    assign obs1 = {bus1.mem_req, bus1.mem_we, bus1.adr_src, irw1, pcw1, pcc1, rgw1, sa1, sb1, op1, rs1, ret1, ill1, st1};
    assign obs2 = {bus2.mem_req, bus2.mem_we, bus2.adr_src, irw2, pcw2, pcc2, rgw2, sa2, sb2, op2, rs2, ret2, ill2, st2};

    function automatic obs_t pick(input int d);
        case (d)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    // Expected outputs for a state, written straight from the control table.
    function automatic obs_t exp_for(input logic [3:0] s, input logic is_r, input logic rdy);
        obs_t e;
        e = '0;
        e.st = s;
        case (s)
            FETCH:    begin e.mem_req = 1; e.b = 2; e.rs = 2; e.ir_write = rdy; e.pc_write = rdy; end
            DECODE:   begin e.a = 1; e.b = 1; end
            EXEC:     begin e.a = 2; e.b = is_r ? 2'd0 : 2'd1; e.op = is_r ? 2'b10 : 2'b00; end
            ALUWB:    begin e.reg_write = 1; e.retire = 1; end
            MEMADDR:  begin e.a = 2; e.b = 1; end
            MEMRD:    begin e.mem_req = 1; e.adr_src = 1; end
            MEMWB:    begin e.reg_write = 1; e.rs = 1; e.retire = 1; end
            MEMWR:    begin e.mem_req = 1; e.mem_we = 1; e.adr_src = 1; e.retire = rdy; end
            BRANCH:   begin e.a = 2; e.op = 2'b01; e.pc_write_cond = 1; e.retire = 1; end
            JAL:      begin e.pc_write = 1; e.a = 1; e.b = 2; end
            JALR_ADR: begin e.a = 2; e.b = 1; end
            JALR_LNK: begin e.pc_write = 1; e.a = 1; e.b = 2; end
            LUI:      begin e.b = 1; e.op = 2'b11; end
            TRAP:     begin e.illegal = 1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic step_raw(input int d, input string nm, input int k, input obs_t e, input logic rdy);
        obs_t got, want;
        exp_q.push_back(e);
        mem_ready = rdy;
        @(negedge clk);
        got  = pick(d);
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d step%0d: got %h want %h (state got %0d want %0d)",
                     nm, d, k, got, want, got.st, want.st);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input string nm);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) step_raw(d, {nm, "_rst"}, i, '0, 1'b1);
        rst = 1'b0;
    endtask

    vec_t  vt    [17];
    string names [17];

    initial begin
        vec_t  v;
        logic  is_r;
        rst       = 1'b1;
        opcode    = 7'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        vt[0]  = '{opc: 7'b0110011, n: 5'd5, dut: 2'd0, st: 64'h3210,      rdy: 16'h000F}; names[0]  = "add";
        vt[1]  = '{opc: 7'b0010011, n: 5'd5, dut: 2'd0, st: 64'h3210,      rdy: 16'h000F}; names[1]  = "addi";
        vt[2]  = '{opc: 7'b0000011, n: 5'd6, dut: 2'd0, st: 64'h65410,     rdy: 16'h001F}; names[2]  = "lw";
        vt[3]  = '{opc: 7'b0100011, n: 5'd5, dut: 2'd0, st: 64'h7410,      rdy: 16'h000F}; names[3]  = "sw";
        vt[4]  = '{opc: 7'b1100011, n: 5'd4, dut: 2'd0, st: 64'h810,       rdy: 16'h0007}; names[4]  = "beq";
        vt[5]  = '{opc: 7'b1101111, n: 5'd5, dut: 2'd0, st: 64'h3910,      rdy: 16'h000F}; names[5]  = "jal";
        vt[6]  = '{opc: 7'b1100111, n: 5'd6, dut: 2'd0, st: 64'h3BA10,     rdy: 16'h001F}; names[6]  = "jalr";
        vt[7]  = '{opc: 7'b0110111, n: 5'd5, dut: 2'd0, st: 64'h3C10,      rdy: 16'h000F}; names[7]  = "lui";
        vt[8]  = '{opc: 7'b0010111, n: 5'd4, dut: 2'd0, st: 64'h310,       rdy: 16'h0007}; names[8]  = "auipc";
        vt[9]  = '{opc: 7'b0000011, n: 5'd9, dut: 2'd0, st: 64'h065555410, rdy: 16'h00C7}; names[9]  = "lw_wait";
        vt[10] = '{opc: 7'b0100011, n: 5'd8, dut: 2'd0, st: 64'h07741000,  rdy: 16'h005C}; names[10] = "sw_wait";
        vt[11] = '{opc: 7'b1111111, n: 5'd7, dut: 2'd0, st: 64'hDDDDD10,   rdy: 16'h007F}; names[11] = "ill_trap";
        vt[12] = '{opc: 7'b1111111, n: 5'd3, dut: 2'd1, st: 64'h010,       rdy: 16'h0003}; names[12] = "ill_notrap";
        vt[13] = '{opc: 7'b0110111, n: 5'd5, dut: 2'd2, st: 64'hDDD10,     rdy: 16'h001F}; names[13] = "lui_off";
        vt[14] = '{opc: 7'b0010111, n: 5'd5, dut: 2'd2, st: 64'hDDD10,     rdy: 16'h001F}; names[14] = "auipc_off";
        vt[15] = '{opc: 7'b1100111, n: 5'd5, dut: 2'd2, st: 64'hDDD10,     rdy: 16'h001F}; names[15] = "jalr_off";
        vt[16] = '{opc: 7'b0110011, n: 5'd5, dut: 2'd2, st: 64'h3210,      rdy: 16'h000F}; names[16] = "add_off";

        for (int r = 0; r < 17; r++) begin
            v      = vt[r];
            opcode = v.opc;
            is_r   = (v.opc == 7'b0110011);
            do_reset(int'(v.dut), names[r]);
            for (int k = 0; k < int'(v.n); k++) begin
                step_raw(int'(v.dut), names[r], k,
                         exp_for(v.st[k*4 +: 4], is_r, v.rdy[k]), v.rdy[k]);
            end
        end

        // Reset while a load waits in MEMRD: outputs drop immediately, no retire, FETCH afterwards.
        opcode = 7'b0000011;
        do_reset(0, "rst_mid");
        step_raw(0, "rst_mid", 0, exp_for(FETCH,   1'b0, 1'b1), 1'b1);
        step_raw(0, "rst_mid", 1, exp_for(DECODE,  1'b0, 1'b1), 1'b1);
        step_raw(0, "rst_mid", 2, exp_for(MEMADDR, 1'b0, 1'b0), 1'b0);
        step_raw(0, "rst_mid", 3, exp_for(MEMRD,   1'b0, 1'b0), 1'b0);
        rst = 1'b1;
        step_raw(0, "rst_mid", 4, '0, 1'b1);
        step_raw(0, "rst_mid", 5, '0, 1'b1);
        rst = 1'b0;
        step_raw(0, "rst_mid", 6, exp_for(FETCH, 1'b0, 1'b0), 1'b0);
        step_raw(0, "rst_mid", 7, exp_for(FETCH, 1'b0, 1'b1), 1'b1);
        step_raw(0, "rst_mid", 8, exp_for(DECODE, 1'b0, 1'b0), 1'b0);

        // A trapped core stays trapped however long memory keeps signalling ready.
        opcode = 7'b1101111;
        do_reset(2, "jal_off");
        step_raw(2, "jal_off", 0, exp_for(FETCH,  1'b0, 1'b1), 1'b1);
        step_raw(2, "jal_off", 1, exp_for(DECODE, 1'b0, 1'b1), 1'b1);
        opcode = 7'b0110011;
        for (int k = 2; k < 6; k++) step_raw(2, "jal_off", k, exp_for(TRAP, 1'b0, 1'b1), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
